// File: rtl/mesh_dma_engine.sv
// rtl/mesh_dma_engine.sv - multi-channel DMA engine issuing word packets onto a mesh network
// Channels share one network port via round-robin; responses return in issue order via a tag FIFO.
module mesh_dma_engine #(
   parameter int channels_p        = 2,
   parameter int addr_width_p      = 16,
   parameter int data_width_p      = 32,
   parameter int len_width_p       = 8,
   parameter int max_out_credits_p = 16,
   parameter int x_cord_width_p    = 4,
   parameter int y_cord_width_p    = 4
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [channels_p-1:0]                cmd_v_i,
   output logic [channels_p-1:0]                cmd_ready_o,
   input  logic [channels_p-1:0]                cmd_we_i,
   input  logic [channels_p*addr_width_p-1:0]   cmd_addr_i,
   input  logic [channels_p*len_width_p-1:0]    cmd_len_i,
   input  logic [channels_p*data_width_p-1:0]   wr_data_i,
   output logic [channels_p-1:0]                wr_yumi_o,
   output logic [channels_p-1:0]                rd_v_o,
   output logic [data_width_p-1:0]              rd_data_o,
   output logic [channels_p-1:0]                done_o,
   output logic                                 out_v_o,
   output logic                                 out_we_o,
   output logic [addr_width_p-1:0]              out_addr_o,
   output logic [data_width_p-1:0]              out_data_o,
   output logic [x_cord_width_p-1:0]            out_x_o,
   output logic [y_cord_width_p-1:0]            out_y_o,
   input  logic                                 out_ready_i,
   input  logic                                 returned_v_i,
   input  logic [data_width_p-1:0]              returned_data_i,
   input  logic [x_cord_width_p-1:0]            dest_x_i,
   input  logic [y_cord_width_p-1:0]            dest_y_i
);

   localparam int id_w   = (channels_p > 1) ? $clog2(channels_p) : 1;
   localparam int cred_w = $clog2(max_out_credits_p) + 1;
   localparam int ptr_w  = (max_out_credits_p > 1) ? $clog2(max_out_credits_p) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

   state_e                   state_q [channels_p];
   state_e                   state_d [channels_p];
   logic [addr_width_p-1:0]  addr_q  [channels_p];
   logic [addr_width_p-1:0]  addr_d  [channels_p];
   logic [len_width_p-1:0]   rem_q   [channels_p];
   logic [len_width_p-1:0]   rem_d   [channels_p];
   logic [channels_p-1:0]    we_q, we_d;
   logic [cred_w-1:0]        ocnt_q  [channels_p];
   logic [cred_w-1:0]        credits_q;
   logic [id_w-1:0]          rr_q, lock_id_q, grant, g_hi, g_lo;
   logic                     lock_q, grant_v, found_hi, accept, pop;
   logic [channels_p-1:0]    issuing;
   logic [id_w:0]            tag_mem [max_out_credits_p];
   logic [ptr_w-1:0]         wr_ptr_q, rd_ptr_q;
   logic [id_w-1:0]          tag_id;
   logic                     tag_we;
   logic                     sel_we;
   logic [addr_width_p-1:0]  sel_addr;
   logic [data_width_p-1:0]  sel_data;

   // A stalled packet keeps its grant (lock) so a newly issuing channel cannot swap the fields.
   always_comb begin
      found_hi = 1'b0;
      g_hi     = '0;
      g_lo     = '0;
      for (int c = channels_p - 1; c >= 0; c--) begin
         issuing[c] = (state_q[c] == S_ISSUE);
         if (issuing[c] && (id_w'(c) >= rr_q)) begin
            found_hi = 1'b1;
            g_hi     = id_w'(c);
         end
         if (issuing[c]) g_lo = id_w'(c);
      end
      grant_v = lock_q || (|issuing);
      grant   = lock_q ? lock_id_q : (found_hi ? g_hi : g_lo);
   end

   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int c = 0; c < channels_p; c++) begin
         if (grant == id_w'(c)) begin
            sel_we   = we_q[c];
            sel_addr = addr_q[c];
            sel_data = wr_data_i[c*data_width_p +: data_width_p];
         end
      end
   end

   assign out_v_o    = grant_v && (credits_q != '0) && !reset_i;
   assign accept     = out_v_o && out_ready_i;
   assign pop        = returned_v_i && (credits_q != cred_w'(max_out_credits_p)) && !reset_i;
   assign out_we_o   = sel_we;
   assign out_addr_o = sel_addr;
   assign out_data_o = sel_we ? sel_data : '0;
   assign out_x_o    = dest_x_i;
   assign out_y_o    = dest_y_i;
   assign tag_id     = tag_mem[rd_ptr_q][id_w:1];
   assign tag_we     = tag_mem[rd_ptr_q][0];
   assign rd_data_o  = returned_data_i;

   always_comb begin
      for (int c = 0; c < channels_p; c++) begin
         cmd_ready_o[c] = reset_i || (state_q[c] == S_IDLE);
         wr_yumi_o[c]   = accept && we_q[c] && (grant == id_w'(c));
         rd_v_o[c]      = pop && !tag_we && (tag_id == id_w'(c));
         done_o[c]      = !reset_i && (state_q[c] == S_DRAIN) && (ocnt_q[c] == '0);
      end
   end

   always_comb begin
      we_d = we_q;
      for (int c = 0; c < channels_p; c++) begin
         state_d[c] = state_q[c];
         addr_d[c]  = addr_q[c];
         rem_d[c]   = rem_q[c];
         case (state_q[c])
            S_IDLE: begin
               if (cmd_v_i[c]) begin
                  state_d[c] = S_ISSUE;
                  addr_d[c]  = cmd_addr_i[c*addr_width_p +: addr_width_p];
                  rem_d[c]   = cmd_len_i[c*len_width_p +: len_width_p];
                  we_d[c]    = cmd_we_i[c];
               end
            end
            S_ISSUE: begin
               if (accept && (grant == id_w'(c))) begin
                  addr_d[c] = addr_q[c] + addr_width_p'(1);
                  if (rem_q[c] == '0) state_d[c] = S_DRAIN;
                  else                rem_d[c]   = rem_q[c] - len_width_p'(1);
               end
            end
            S_DRAIN: begin
               if (ocnt_q[c] == '0) state_d[c] = S_IDLE;
            end
            default: state_d[c] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         we_q <= '0;
         for (int c = 0; c < channels_p; c++) begin
            state_q[c] <= S_IDLE;
            addr_q[c]  <= '0;
            rem_q[c]   <= '0;
         end
      end else begin
         we_q <= we_d;
         for (int c = 0; c < channels_p; c++) begin
            state_q[c] <= state_d[c];
            addr_q[c]  <= addr_d[c];
            rem_q[c]   <= rem_d[c];
         end
      end
   end

   // FIFO occupancy is implied by credits, so empty is simply credits == max.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         credits_q <= cred_w'(max_out_credits_p);
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rr_q      <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         for (int c = 0; c < channels_p; c++) ocnt_q[c] <= '0;
      end else begin
         if (accept && !pop)      credits_q <= credits_q - cred_w'(1);
         else if (pop && !accept) credits_q <= credits_q + cred_w'(1);
         if (accept) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + ptr_w'(1);
         if (accept) rr_q <= (grant == id_w'(channels_p - 1)) ? '0 : grant + id_w'(1);
         lock_q    <= out_v_o && !out_ready_i;
         lock_id_q <= grant;
         for (int c = 0; c < channels_p; c++) begin
            if ((accept && grant == id_w'(c)) && !(pop && tag_id == id_w'(c)))
               ocnt_q[c] <= ocnt_q[c] + cred_w'(1);
            else if (!(accept && grant == id_w'(c)) && (pop && tag_id == id_w'(c)))
               ocnt_q[c] <= ocnt_q[c] - cred_w'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) tag_mem[wr_ptr_q] <= {grant, sel_we};
   end

endmodule

// File: doc/mesh_dma_engine.md
MESH_DMA_ENGINE -- requirements
Module: mesh_dma_engine

Interface
REQ-001 SHALL have parameter channels_p, default 2, number of independent DMA channels.
REQ-002 SHALL have parameter addr_width_p, default 16, word address width.
REQ-003 SHALL have parameter data_width_p, default 32, data word width.
REQ-004 SHALL have parameter len_width_p, default 8, burst length field width.
REQ-005 SHALL have parameter max_out_credits_p, default 16, maximum outstanding network packets (power of 2).
REQ-006 SHALL have parameters x_cord_width_p and y_cord_width_p, default 4 each, mesh coordinate widths.
REQ-007 SHALL have ports clk_i input 1, the single clock, and reset_i input 1; reset is asynchronous and active-high.
REQ-008 SHALL have per-channel command ports: cmd_v_i, cmd_ready_o and cmd_we_i, each input/output/input channels_p wide; cmd_addr_i input channels_p*addr_width_p; cmd_len_i input channels_p*len_width_p (words minus 1).
REQ-009 SHALL have per-channel write-data ports: wr_data_i input channels_p*data_width_p and wr_yumi_o output channels_p (word consumed).
REQ-010 SHALL have read-return ports: rd_v_o output channels_p (one-hot) and rd_data_o output data_width_p; also done_o output channels_p (1-cycle pulse).
REQ-011 SHALL have network ports: out_v_o 1, out_we_o 1, out_addr_o addr_width_p, out_data_o data_width_p, out_x_o/out_y_o coordinate widths (outputs); out_ready_i 1 input; returned_v_i 1 and returned_data_i data_width_p inputs; dest_x_i/dest_y_i inputs.

Function
REQ-012 SHALL give each channel a FSM IDLE -> ISSUE -> DRAIN -> IDLE; cmd_ready_o[c]=1 only in IDLE; cmd_v_i&cmd_ready_o latches addr, len, we and enters ISSUE.
REQ-013 SHALL in ISSUE issue len+1 packets at addresses base, base+1, ...; address wraps modulo 2^addr_width_p.
REQ-014 SHALL leave ISSUE after the last packet is accepted, then stay in DRAIN until that channel's outstanding count is 0, then pulse done_o[c] for one cycle and return to IDLE.
REQ-015 SHALL round-robin arbitrate among ISSUE channels; the pointer advances past the granted channel only on acceptance (out_v_o&out_ready_i).
REQ-016 SHALL drive out_v_o only when a channel is granted and credits available > 0; out_v_o, once asserted, SHALL hold its fields stable until accepted.
REQ-017 SHALL for stores drive out_data_o=wr_data_i[granted] and pulse wr_yumi_o[granted] on acceptance; load packets drive out_data_o=0.
REQ-018 SHALL drive out_x_o/out_y_o from dest_x_i/dest_y_i.
REQ-019 SHALL keep a credit counter: decremented on acceptance, incremented on returned_v_i, unchanged if both in the same cycle; never exceeds max_out_credits_p.
REQ-020 SHALL push {channel id, we} to an in-order tag FIFO of depth max_out_credits_p on acceptance and pop on returned_v_i; responses return in issue order.
REQ-021 SHALL on a popped load tag assert rd_v_o[id] with rd_data_o=returned_data_i in the same cycle (zero latency); store responses produce no rd_v_o.
REQ-022 SHALL decrement the owning channel's outstanding count on each pop; push and pop for the same channel in one cycle leave it unchanged.
REQ-023 SHALL ignore returned_v_i when the tag FIFO is empty (no pop, no rd_v_o, credits unchanged).

Reset
REQ-024 SHALL on reset_i asynchronously set all FSMs to IDLE, credits to max_out_credits_p, tag FIFO empty, arbiter pointer 0, outstanding counts 0.
REQ-025 SHALL while reset_i is asserted drive out_v_o, rd_v_o, wr_yumi_o, done_o to 0 and cmd_ready_o to all-ones; reset mid-burst discards the burst with no done_o pulse.

Verification
REQ-026 Ch0 load addr 0x10 len 3, out_ready_i=1, responses after 5 cycles -> 4 packets at 0x10..0x13, rd_v_o[0] x4 in order, done_o[0] one cycle after last response.
REQ-027 Ch0 and ch1 stores len 1 simultaneously -> accepted order ch0,ch1,ch0,ch1; wr_yumi_o pulses match; both done_o after 4 responses.
REQ-028 Withhold returns, 20-word load -> exactly 16 packets accepted, out_v_o=0 until first returned_v_i, then resumes.
REQ-029 out_ready_i=0 for 3 cycles during store -> out_addr_o/out_data_o stable, no wr_yumi_o until acceptance.
REQ-030 Load at addr 0xFFFE len 2 -> packets 0xFFFE, 0xFFFF, 0x0000.
REQ-031 Assert reset_i mid-burst with 5 outstanding -> outputs 0 immediately, credits 16, cmd_ready_o all-ones, no done_o.
